// File: rtl/mc_data_memory.sv
// -----------------------------------------------------------------------------
// mc_data_memory
//
// Multi-cycle, byte-addressable data memory for the CPU load/store port.
// One request is accepted at a time over a valid/ready handshake; the
// response appears a fixed LATENCY cycles after acceptance. Byte, half and
// word accesses are supported with sign or zero extension on loads.
// Misaligned or illegal-size requests are flagged and perform no access.
// The storage array is never reset; only control/response state is.
//
// Parameters
//   MEM_DEPTH  number of 32-bit words (power of two, >= 4)
//   LATENCY    cycles from acceptance to response (>= 1)
//
// Ports
//   clk           clock, rising edge
//   reset         asynchronous active-low reset (control state only)
//   req_valid     request present
//   req_ready     high exactly while idle
//   req_write     1 = store, 0 = load
//   req_addr      byte address (upper bits alias)
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata     store data, right-aligned
//   resp_valid    one-cycle completion pulse
//   resp_rdata    load result (0 for stores and errors), held until next commit
//   resp_err      misaligned / illegal size, held until next commit
// -----------------------------------------------------------------------------
module mc_data_memory #(
   parameter int MEM_DEPTH = 16384,
   parameter int LATENCY   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int ADDR_W = $clog2(MEM_DEPTH);
   // Counter only ever holds LATENCY-2 down to 0.
   localparam int CNT_W  = (LATENCY > 2) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : CNT_W'(0);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_WAIT = 2'b01,
      S_RESP = 2'b10
   } state_t;

   // ---------------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------------

   // Half must be 2-byte aligned, word 4-byte aligned, size 11 is never legal.
   function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
      logic e;
      case (size)
         2'b00:   e = 1'b0;
         2'b01:   e = lane[0];
         2'b10:   e = (lane != 2'b00);
         default: e = 1'b1;
      endcase
      return e;
   endfunction

   // Shift the addressed lane(s) down to bit 0 and extend to 32 bits.
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic        uns);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {lane, 3'b000};
      case (size)
         2'b00:   res = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
         2'b01:   res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: res = word;
      endcase
      return res;
   endfunction

   // Replicate right-aligned store data across the lanes it may land in.
   function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input logic [1:0] size);
      logic [31:0] res;
      case (size)
         2'b00:   res = {4{wdata[7:0]}};
         2'b01:   res = {2{wdata[15:0]}};
         default: res = wdata;
      endcase
      return res;
   endfunction

   function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] be;
      case (size)
         2'b00:   be = 4'b0001 << lane;
         2'b01:   be = 4'b0011 << lane;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                write_q;
   logic [ADDR_W+1:0]   addr_q;
   logic [1:0]          size_q;
   logic                uns_q;
   logic [31:0]         wdata_q;
   logic                rvalid_q;
   logic [31:0]         rdata_q;
   logic                err_q;

   logic [31:0]         mem_q [MEM_DEPTH];

   // Address bits above the array index are deliberately ignored (aliasing).
   logic                unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

   // ---------------------------------------------------------------------------
   // Commit-side request view
   // ---------------------------------------------------------------------------
   // With LATENCY = 1 the commit happens on the acceptance edge itself, so the
   // live request fields are used while idle; otherwise the latched copy.
   logic                sel_live;
   logic                cur_write;
   logic [ADDR_W+1:0]   cur_addr;
   logic [1:0]          cur_size;
   logic                cur_uns;
   logic [31:0]         cur_wdata;
   logic [1:0]          cur_lane;
   logic [ADDR_W-1:0]   cur_widx;

   assign sel_live  = (state_q == S_IDLE);
   assign cur_write = sel_live ? req_write                : write_q;
   assign cur_addr  = sel_live ? req_addr[ADDR_W+1:0]     : addr_q;
   assign cur_size  = sel_live ? req_size                 : size_q;
   assign cur_uns   = sel_live ? req_unsigned             : uns_q;
   assign cur_wdata = sel_live ? req_wdata                : wdata_q;
   assign cur_lane  = cur_addr[1:0];
   assign cur_widx  = cur_addr[ADDR_W+1:2];

   logic                accept;
   logic                commit_d;
   logic                err_d;
   logic [31:0]         rword;
   logic [31:0]         load_d;
   logic [31:0]         wlane_d;
   logic [3:0]          be_d;

   assign accept   = req_valid && (state_q == S_IDLE);
   // Commit happens on the edge that enters RESP.
   assign commit_d = (LATENCY == 1) ? accept
                                    : ((state_q == S_WAIT) && (cnt_q == CNT_W'(0)));
   assign err_d    = access_err(cur_size, cur_lane);
   assign rword    = mem_q[cur_widx];
   assign load_d   = load_extract(rword, cur_lane, cur_size, cur_uns);
   assign wlane_d  = store_lanes(cur_wdata, cur_size);
   assign be_d     = store_be(cur_size, cur_lane);

   // ---------------------------------------------------------------------------
   // Storage array (not reset). A store is suppressed while reset is held so
   // an abandoned request can never reach the array.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset && commit_d && cur_write && !err_d) begin
         for (int b = 0; b < 4; b++) begin
            if (be_d[b]) begin
               mem_q[cur_widx][8*b +: 8] <= wlane_d[8*b +: 8];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM with registered response outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= CNT_W'(0);
         write_q  <= 1'b0;
         addr_q   <= '0;
         size_q   <= 2'b00;
         uns_q    <= 1'b0;
         wdata_q  <= 32'd0;
         rvalid_q <= 1'b0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         if (commit_d) begin
            rvalid_q <= 1'b1;
            err_q    <= err_d;
            rdata_q  <= (cur_write || err_d) ? 32'd0 : load_d;
         end

         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  write_q <= req_write;
                  addr_q  <= req_addr[ADDR_W+1:0];
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  wdata_q <= req_wdata;
                  if (LATENCY == 1) begin
                     state_q <= S_RESP;
                  end else begin
                     state_q <= S_WAIT;
                     cnt_q   <= CNT_LOAD;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == CNT_W'(0)) begin
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = rvalid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule
